// File: rtl/sync_mutex_split8_if.sv
// Handshake bundle for the 1-to-8 token splitter: upstream drive/free,
// eight downstream drive/free lanes, plus status flags.
interface sync_mutex_split8_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_drive;
  logic [2:0]            i_sel;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_free;
  logic [7:0]            o_drive;
  logic [DATA_WIDTH-1:0] o_data;
  logic [7:0]            i_free;
  logic                  o_busy;
  logic                  o_err;

  // The splitter itself: consumes upstream drive and downstream frees.
  modport slave (
    input  i_drive, i_sel, i_data, i_free,
    output o_free, o_drive, o_data, o_busy, o_err
  );

  // The environment around the splitter.
  modport master (
    output i_drive, i_sel, i_data, i_free,
    input  o_free, o_drive, o_data, o_busy, o_err
  );
endinterface

// File: rtl/sync_mutex_split8.sv
// Clocked 1-to-8 token splitter. Captures one upstream token, forwards a
// one-hot drive pulse to the selected lane after DRIVE_DELAY cycles, and
// returns the upstream free FREE_DELAY cycles after that lane frees it.
// Protocol violations are ignored but latch a sticky error flag.
module sync_mutex_split8 #(
  parameter int DATA_WIDTH  = 32,
  parameter int DRIVE_DELAY = 4,   // legal 1..15
  parameter int FREE_DELAY  = 4    // legal 1..15
) (
  input logic              clk,
  input logic              rst,
  sync_mutex_split8_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DLY_DRV,
    S_WAIT_FREE,
    S_DLY_FREE
  } state_t;

  localparam logic [3:0] DRV_LOAD  = 4'(DRIVE_DELAY - 1);
  localparam logic [3:0] FREE_LOAD = 4'(FREE_DELAY - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [2:0]            r_cur_sel;
  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            r_drive;
  logic                  r_free;
  logic                  r_busy;
  logic                  r_err;

  logic [7:0]            w_sel_mask;
  logic                  w_free_hit;
  logic                  w_stray_free;
  logic                  w_drive_err;

  assign w_sel_mask = 8'b0000_0001 << r_cur_sel;

  // Only WAIT_FREE accepts a free, and only on the held lane; any other
  // asserted free bit (including extras alongside the right one) is stray.
  assign w_free_hit   = (r_state == S_WAIT_FREE) && ((bus.i_free & w_sel_mask) != 8'h00);
  assign w_stray_free = (r_state == S_WAIT_FREE) ? ((bus.i_free & ~w_sel_mask) != 8'h00)
                                                 : (bus.i_free != 8'h00);
  assign w_drive_err  = bus.i_drive && (r_state != S_IDLE);

  // Token FSM with shared delay counter; every output is a register.
  // DLY_FREE lingers one extra cycle while o_free is high so a drive that
  // coincides with the o_free pulse is still seen as illegal and o_busy
  // drops on the edge that ends the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_cur_sel <= 3'd0;
      r_data    <= '0;
      r_drive   <= 8'h00;
      r_free    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_drive <= 8'h00;
      if (w_drive_err || w_stray_free) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_free <= 1'b0;
          if (bus.i_drive) begin
            r_data    <= bus.i_data;
            r_cur_sel <= bus.i_sel;
            r_cnt     <= DRV_LOAD;
            r_busy    <= 1'b1;
            r_state   <= S_DLY_DRV;
          end
        end
        S_DLY_DRV: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_drive <= w_sel_mask;
            r_state <= S_WAIT_FREE;
          end
        end
        S_WAIT_FREE: begin
          if (w_free_hit) begin
            r_cnt   <= FREE_LOAD;
            r_state <= S_DLY_FREE;
          end
        end
        S_DLY_FREE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_free) begin
            r_free <= 1'b1;
          end else begin
            r_free  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_drive = r_drive;
  assign bus.o_free  = r_free;
  assign bus.o_data  = r_data;
  assign bus.o_busy  = r_busy;
  assign bus.o_err   = r_err;

endmodule

// File: tb/tb_sync_mutex_split8.sv
// Directed bench for the 1-to-8 token splitter. Instance A uses delays of 4,
// instance B uses delays of 1 for the back-to-back case. Inputs change and
// outputs are sampled on the falling edge.
module tb_sync_mutex_split8;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  int   cyc;
  int   acc_cyc;
  logic use_b;

  sync_mutex_split8_if #(.DATA_WIDTH(32)) a_if();
  sync_mutex_split8_if #(.DATA_WIDTH(32)) b_if();

  sync_mutex_split8 #(.DATA_WIDTH(32), .DRIVE_DELAY(4), .FREE_DELAY(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  sync_mutex_split8 #(.DATA_WIDTH(32), .DRIVE_DELAY(1), .FREE_DELAY(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  logic [7:0]  m_drive;
  logic        m_free;
  logic [31:0] m_data;
  logic        m_busy;
  logic        m_err;
  assign m_drive = use_b ? b_if.o_drive : a_if.o_drive;
  assign m_free  = use_b ? b_if.o_free  : a_if.o_free;
  assign m_data  = use_b ? b_if.o_data  : a_if.o_data;
  assign m_busy  = use_b ? b_if.o_busy  : a_if.o_busy;
  assign m_err   = use_b ? b_if.o_err   : a_if.o_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Present a drive for one rising edge; leaves us on the next falling edge.
  task automatic send(input logic b, input logic [2:0] s, input logic [31:0] d);
    use_b = b;
    if (b) begin b_if.i_drive = 1'b1; b_if.i_sel = s; b_if.i_data = d; end
    else   begin a_if.i_drive = 1'b1; a_if.i_sel = s; a_if.i_data = d; end
    @(negedge clk);
    acc_cyc = cyc;
    if (b) begin b_if.i_drive = 1'b0; b_if.i_data = '0; end
    else   begin a_if.i_drive = 1'b0; a_if.i_data = '0; end
  endtask

  task automatic free_pulse(input logic b, input logic [7:0] mask);
    use_b = b;
    if (b) b_if.i_free = mask; else a_if.i_free = mask;
    @(negedge clk);
    if (b) b_if.i_free = 8'h00; else a_if.i_free = 8'h00;
  endtask

  // Falling edges until a downstream drive shows; 20 means it never came.
  task automatic wait_drive(output int n);
    n = 0;
    while (m_drive == 8'h00 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_free(output int n);
    n = 0;
    while (!m_free && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Count o_free pulses over a window of falling edges.
  task automatic count_free(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (m_free) hits++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One complete token: accept, routed drive, optional gap, free, upstream free.
  task automatic run_token(input logic b, input logic [2:0] s, input logic [31:0] d,
                           input int gap, input int dd, input int fd, input string tag);
    int n;
    send(b, s, d);
    chk({tag, " busy"}, 32'(m_busy), 32'd1);
    wait_drive(n);
    chk({tag, " drv_lat"}, 32'(n), 32'(dd));
    chk({tag, " drv_val"}, 32'(m_drive), 32'(8'b1 << s));
    chk({tag, " data"}, m_data, d);
    if (gap == 0) begin
      free_pulse(b, 8'b1 << s);
      chk({tag, " drv_wid"}, 32'(m_drive), 32'd0);
    end else begin
      @(negedge clk);
      chk({tag, " drv_wid"}, 32'(m_drive), 32'd0);
      repeat (gap - 1) @(negedge clk);
      free_pulse(b, 8'b1 << s);
    end
    wait_free(n);
    chk({tag, " free_lat"}, 32'(n), 32'(fd));
    @(negedge clk);
    chk({tag, " free_wid"}, 32'(m_free), 32'd0);
    chk({tag, " idle"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    int n;
    int hits;
    int prev;
    vec_cnt = 0;
    err_cnt = 0;
    cyc     = 0;
    acc_cyc = 0;
    use_b   = 1'b0;
    rst     = 1'b1;
    a_if.i_drive = 1'b0; a_if.i_sel = 3'd0; a_if.i_data = '0; a_if.i_free = 8'h00;
    b_if.i_drive = 1'b0; b_if.i_sel = 3'd0; b_if.i_data = '0; b_if.i_free = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst drive", 32'(a_if.o_drive), 32'd0);
    chk("rst free", 32'(a_if.o_free), 32'd0);
    chk("rst data", a_if.o_data, 32'd0);
    chk("rst busy", 32'(a_if.o_busy), 32'd0);
    chk("rst err", 32'(a_if.o_err), 32'd0);

    // 1: basic routing, free 3 cycles after the drive pulse
    run_token(1'b0, 3'd5, 32'hA5A5_0005, 3, 4, 4, "t1");
    chk("t1 err", 32'(m_err), 32'd0);

    // 2: every lane in turn, freed immediately
    for (int s = 0; s < 8; s++) begin
      run_token(1'b0, 3'(s), 32'(s), 0, 4, 4, $sformatf("t2 sel%0d", s));
    end
    chk("t2 err", 32'(m_err), 32'd0);

    // 6: minimum delays, each new drive on the first legal edge
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      run_token(1'b1, 3'(k + 2), 32'hB000_0000 + 32'(k), 0, 1, 1, $sformatf("t6 tok%0d", k));
      if (k > 0) chk($sformatf("t6 period%0d", k), 32'(acc_cyc - prev), 32'd5);
      prev = acc_cyc;
    end
    chk("t6 err", 32'(b_if.o_err), 32'd0);

    // 3: wrong-lane free is ignored but flagged
    send(1'b0, 3'd2, 32'h0000_3333);
    wait_drive(n);
    chk("t3 drv_val", 32'(m_drive), 32'h04);
    free_pulse(1'b0, 8'h40);
    count_free(6, hits);
    chk("t3 no_free", 32'(hits), 32'd0);
    chk("t3 err", 32'(m_err), 32'd1);
    chk("t3 still_busy", 32'(m_busy), 32'd1);
    free_pulse(1'b0, 8'h04);
    wait_free(n);
    chk("t3 free_lat", 32'(n), 32'd4);
    @(negedge clk);
    chk("t3 idle", 32'(m_busy), 32'd0);

    // 4: drive while busy is dropped
    do_reset();
    chk("t4 err_clr", 32'(a_if.o_err), 32'd0);
    send(1'b0, 3'd1, 32'h0000_1111);
    send(1'b0, 3'd3, 32'h0000_2222);
    wait_drive(n);
    chk("t4 drv_lat", 32'(n), 32'd3);
    chk("t4 drv_val", 32'(m_drive), 32'h02);
    chk("t4 data", m_data, 32'h0000_1111);
    chk("t4 err", 32'(m_err), 32'd1);
    free_pulse(1'b0, 8'h02);
    wait_free(n);
    chk("t4 free_lat", 32'(n), 32'd4);
    @(negedge clk);
    chk("t4 idle", 32'(m_busy), 32'd0);

    // 5: async reset in WAIT_FREE drops the token
    do_reset();
    send(1'b0, 3'd6, 32'hCAFE_0006);
    wait_drive(n);
    chk("t5 drv_val", 32'(m_drive), 32'h40);
    rst = 1'b1;
    #1;
    chk("t5 async drive", 32'(a_if.o_drive), 32'd0);
    chk("t5 async data", a_if.o_data, 32'd0);
    chk("t5 async busy", 32'(a_if.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    free_pulse(1'b0, 8'h40);
    count_free(6, hits);
    chk("t5 no_free", 32'(hits), 32'd0);
    chk("t5 err", 32'(m_err), 32'd1);
    run_token(1'b0, 3'd4, 32'h5555_0004, 0, 4, 4, "t5 new");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
